// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, fixed latency of WIDTH+2 cycles.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StSign} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_a, add_b;
    logic [WIDTH+1:0]   sum;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == CntW'(WIDTH - 1)) state_d = StSign;
            StSign:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == StRun) || (state_q == StSign);
    end

    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Signed ops iterate on magnitudes; signs are restored in StSign.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & opa[WIDTH-1];
        b_neg     = signed_op & opb[WIDTH-1];
        abs_a     = a_neg ? -opa : opa;
        abs_b     = b_neg ? -opb : opb;
    end

    // Shared WIDTH+1-bit adder; for divide it subtracts and the carry-out means rem >= divisor.
    always_comb begin
        add_a = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        add_b = is_div_q ? ~{1'b0, b_q} : {1'b0, b_q};
        sum   = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div_q};
        ge    = sum[WIDTH+1];
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        opa_d     = opa_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d     = {{WIDTH{1'b0}}, abs_a};
                    b_d       = abs_b;
                    opa_d     = opa;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dbz_d     = op[1] && (opb == '0);
                end else begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (is_div_q) begin
                    acc_d = {(ge ? sum[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                             acc_q[WIDTH-2:0], ge};
                end else if (acc_q[0]) begin
                    acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
            end
            StSign: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    if (dbz_q) begin
                        lo_d = '1;
                        hi_d = opa_q;
                    end else begin
                        lo_d = quo;
                        hi_d = rem;
                    end
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            opa_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            opa_q     <= opa_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: a 32-bit instance plus an 8-bit instance.
module tb_muldiv_unit;

    logic        clk;
    logic        rst, start, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] opa, opb, wr_data;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        rst8, start8, busy8, done8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  opa8, opb8, hi8, lo8;

    int n_checks;
    int n_fail;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .opa(opa8), .opb(opb8),
        .wr_hi(1'b0), .wr_lo(1'b0), .wr_data(8'h00),
        .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op on the 32-bit unit and wait for done; lat counts cycles from the start edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input bit wr_with_start,
                         output int lat, output int busy_n, output logic dbz1);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        if (wr_with_start) begin wr_lo = 1'b1; wr_data = 32'h0000_0055; end
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        lat = 1; busy_n = 0; dbz1 = dbz;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            if (disturb && lat == 5) begin
                start = 1'b1; op = 2'b11; opa = 32'd1; opb = 32'd1;
                wr_lo = 1'b1; wr_data = 32'h1234_5678;
            end else if (disturb && lat == 6) begin
                start = 1'b0; wr_lo = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", dbz); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        rst = 1'b0; rst8 = 1'b0;
    endtask

    task automatic test_multu_max();
        int lat, bn; logic d1;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL multu_latency: got %0d want 34", lat); end
        n_checks++; if (bn != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bn); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL multu_dbz: got %b want 0", dbz); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", done); end
    endtask

    task automatic test_signed();
        int lat, bn; logic d1;
        do_op(2'b00, -32'sd7, 32'd3, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        do_op(2'b10, -32'sd7, 32'd2, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_quo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_rem: got %h want ffffffff", hi); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_latency: got %0d want 34", lat); end
        do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_quo: got %h want 3", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_rem: got %h want 1", hi); end
        do_op(2'b10, 32'd7, -32'sd2, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_quo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL div_negb_rem: got %h want 1", hi); end
    endtask

    task automatic test_dbz();
        int lat, bn; logic d1;
        do_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo: got %h want ffffffff", lo); end
        n_checks++; if (hi !== 32'h0000_0007) begin n_fail++; $display("FAIL dbz_hi: got %h want 00000007", hi); end
        n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", dbz); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL dbz_latency: got %0d want 34", lat); end
        repeat (3) @(negedge clk);
        n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_held: got %b want 1", dbz); end
        do_op(2'b10, -32'sd5, 32'd0, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL dbz_signed_hi: got %h want fffffffb", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_signed_lo: got %h want ffffffff", lo); end
        do_op(2'b11, 32'd9, 32'd3, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (d1 !== 1'b0) begin n_fail++; $display("FAIL dbz_clear_on_start: got %b want 0", d1); end
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_after_dbz: got %h want 3", lo); end
    endtask

    task automatic test_min();
        int lat, bn; logic d1;
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL min_div_lo: got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL min_div_hi: got %h want 0", hi); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL min_div_dbz: got %b want 0", dbz); end
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat, bn, d1);
        n_checks++; if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL min_mult_hi: got %h want 40000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL min_mult_lo: got %h want 0", lo); end
    endtask

    task automatic test_hilo_writes();
        int lat, bn; logic d1;
        do_op(2'b00, -32'sd7, 32'd3, 1'b1, 1'b0, lat, bn, d1);
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL disturb_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL disturb_lo: got %h want ffffffeb", lo); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL disturb_latency: got %0d want 34", lat); end
        wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_hi = 1'b0;
        n_checks++; if (hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mthi: got %h want deadbeef", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mthi_lo_kept: got %h want ffffffeb", lo); end
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5_0F0F;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        n_checks++; if (hi !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL both_hi: got %h want a5a50f0f", hi); end
        n_checks++; if (lo !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL both_lo: got %h want a5a50f0f", lo); end
        do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b1, lat, bn, d1);
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL start_wins_lo: got %h want 3", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL start_wins_hi: got %h want 1", hi); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mid_rst_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL mid_rst_lo: got %h want 0", lo); end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_done: got %b want 0", saw_done); end
    endtask

    task automatic test_width8();
        int lat;
        @(negedge clk);
        start8 = 1'b1; op8 = 2'b00; opa8 = 8'h80; opb8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (hi8 !== 8'h40) begin n_fail++; $display("FAIL w8_hi: got %h want 40", hi8); end
        n_checks++; if (lo8 !== 8'h00) begin n_fail++; $display("FAIL w8_lo: got %h want 00", lo8); end
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL w8_latency: got %0d want 10", lat); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; rst8 = 1'b1;
        start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        start8 = 1'b0; op8 = 2'b00; opa8 = '0; opb8 = '0;
        test_reset();
        test_multu_max();
        test_signed();
        test_dbz();
        test_min();
        test_hilo_writes();
        test_reset_mid();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
